sipo: RTL

- Serial-In-Parallel-Out receiver; the receive-side counterpart of the PISO transmitter.
- Samples one serial bit per clock when valid_in is high and assembles DATA_WIDTH bits MSB-first into a parallel word.
- Presents the word with a one-cycle valid_out strobe.
- Connects directly to the PISO serial outputs (PISO data_out -> sipo data_in, PISO valid_out -> sipo valid_in).

---
 rtl/sipo_pkg.sv | 17 +
 rtl/sipo_gap_timer.sv | 33 +++
 rtl/sipo.sv | 99 +++++++++
 3 files changed

// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the sipo serial-in parallel-out receiver.
// Imported by sipo and sipo_gap_timer.
package sipo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } sipo_state_t;

    localparam int SIPO_DEFAULT_WIDTH = 8;

    // Wide enough to hold every count from 0 up to and including width.
    function automatic int sipo_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_gap_timer.sv
// Counts consecutive idle cycles inside a partial word for sipo.
// Only instantiated when SIPO_TIMEOUT_EN is defined.
module sipo_gap_timer
    import sipo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int GapW = sipo_cnt_width(TIMEOUT_CYCLES);
    localparam logic [GapW-1:0] LastGap = GapW'(TIMEOUT_CYCLES - 1);

    logic [GapW-1:0] gap_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (clear) begin
            gap_cnt <= '0;
        end else if (enable) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // Fires on the idle cycle whose increment brings the count to TIMEOUT_CYCLES.
    assign expired = enable && (gap_cnt == LastGap);

endmodule

// File: rtl/sipo.sv
// Serial-in parallel-out receiver: assembles DATA_WIDTH bits MSB-first and strobes valid_out.
// Define SIPO_TIMEOUT_EN to discard partial words after TIMEOUT_CYCLES idle cycles.
module sipo
    import sipo_pkg::*;
#(
    parameter int DATA_WIDTH     = SIPO_DEFAULT_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int CntW = sipo_cnt_width(DATA_WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

    sipo_state_t           state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CntW-1:0]       bit_cnt;
    logic [DATA_WIDTH-1:0] next_shift;
    logic                  gap_expired;

    assign next_shift = {shift_reg[DATA_WIDTH-2:0], data_in};

`ifdef SIPO_TIMEOUT_EN
    sipo_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (state == RECV && !valid_in),
        .clear  (valid_in || state == IDLE),
        .expired(gap_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= gap_expired;
        end
    end
`else
    assign gap_expired = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        shift_reg <= next_shift;
                        bit_cnt   <= CntW'(1);
                        state     <= RECV;
                        busy      <= 1'b1;
                    end
                end
                RECV: begin
                    if (valid_in) begin
                        shift_reg <= next_shift;
                        if (bit_cnt == LastBit) begin
                            // Completing edge: publish the word and be ready for the next bit at once.
                            data_out  <= next_shift;
                            valid_out <= 1'b1;
                            bit_cnt   <= '0;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (gap_expired) begin
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
